add_arbiter: RTL

//  Shares one sign-magnitude add/sub unit (start/finish handshake, 16-bit) between two requesters.

---
 rtl/add_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/add_arbiter.sv
// add_arbiter: round-robin sharing of one start/finish sign-magnitude add/sub unit
// between two requesters, with -0 normalisation, overflow flag and a hang watchdog.
module add_arbiter #(
   parameter int TIMEOUT = 8
) (
   input  logic        clk,
   input  logic        nRST,
   input  logic        req0,
   input  logic [15:0] a0,
   input  logic [15:0] b0,
   input  logic        sub0,
   input  logic        req1,
   input  logic [15:0] a1,
   input  logic [15:0] b1,
   input  logic        sub1,
   output logic        ack0,
   output logic        ack1,
   output logic        rsp_valid0,
   output logic        rsp_valid1,
   output logic [15:0] rsp_data,
   output logic        rsp_ovf,
   output logic        rsp_err,
   output logic        busy,
   output logic        add_start,
   output logic [15:0] add_in1,
   output logic [15:0] add_in2,
   output logic        add_sub,
   input  logic [15:0] add_out,
   input  logic        add_finish
);

   localparam int WD_W = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_RESP  = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t          r_state;
   logic            r_last;
   logic            r_gnt;
   logic [WD_W-1:0] r_wd;
   logic            r_ack0;
   logic            r_ack1;
   logic            r_rsp_valid0;
   logic            r_rsp_valid1;
   logic [15:0]     r_rsp_data;
   logic            r_rsp_ovf;
   logic            r_rsp_err;
   logic            r_start;
   logic [15:0]     r_in1;
   logic [15:0]     r_in2;
   logic            r_sub;

   logic            w_any_req;
   logic            w_sel;
   logic            w_eff_same;
   logic            w_ovf;
   logic [15:0]     w_data;
   logic            w_wd_expired;

   // On a tie the requester that did not win last time is chosen.
   assign w_any_req    = req0 | req1;
   assign w_sel        = (req0 && req1) ? ~r_last : req1;

   // Same effective signs means a magnitude add; a wrapped sum is smaller than a.
   assign w_eff_same   = (r_in1[15] == (r_in2[15] ^ r_sub));
   assign w_ovf        = w_eff_same && (add_out[14:0] < r_in1[14:0]);
   assign w_data       = (add_out[14:0] == 15'd0) ? 16'h0000 : add_out;
   assign w_wd_expired = (r_wd == WD_W'(TIMEOUT - 1));

   // NOTE: every register here, state included, uses non-blocking assignment and
   // the asynchronous active-low reset, so the adder and arbiter clear together.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         r_state      <= S_IDLE;
         r_last       <= 1'b1;
         r_gnt        <= 1'b0;
         r_wd         <= '0;
         r_ack0       <= 1'b0;
         r_ack1       <= 1'b0;
         r_rsp_valid0 <= 1'b0;
         r_rsp_valid1 <= 1'b0;
         r_rsp_data   <= 16'h0000;
         r_rsp_ovf    <= 1'b0;
         r_rsp_err    <= 1'b0;
         r_start      <= 1'b0;
         r_in1        <= 16'h0000;
         r_in2        <= 16'h0000;
         r_sub        <= 1'b0;
      end else begin
         r_ack0       <= 1'b0;
         r_ack1       <= 1'b0;
         r_rsp_valid0 <= 1'b0;
         r_rsp_valid1 <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  r_gnt   <= w_sel;
                  r_last  <= w_sel;
                  r_in1   <= w_sel ? a1 : a0;
                  r_in2   <= w_sel ? b1 : b0;
                  r_sub   <= w_sel ? sub1 : sub0;
                  r_ack0  <= ~w_sel;
                  r_ack1  <= w_sel;
                  r_start <= 1'b1;
                  r_wd    <= '0;
                  r_state <= S_RUN;
               end
            end

            S_RUN: begin
               if (add_finish) begin
                  r_rsp_data   <= w_data;
                  r_rsp_ovf    <= w_ovf;
                  r_rsp_err    <= 1'b0;
                  r_start      <= 1'b0;
                  r_rsp_valid0 <= ~r_gnt;
                  r_rsp_valid1 <= r_gnt;
                  r_state      <= S_RESP;
               end else if (w_wd_expired) begin
                  r_rsp_data   <= 16'h0000;
                  r_rsp_ovf    <= 1'b0;
                  r_rsp_err    <= 1'b1;
                  r_start      <= 1'b0;
                  r_rsp_valid0 <= ~r_gnt;
                  r_rsp_valid1 <= r_gnt;
                  r_state      <= S_RESP;
               end else begin
                  r_wd <= r_wd + WD_W'(1);
               end
            end

            S_RESP: begin
               r_state <= S_DRAIN;
            end

            S_DRAIN: begin
               // Hold off until the adder has left FIN so a new start is not merged.
               if (!add_finish) begin
                  r_state <= S_IDLE;
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign ack0       = r_ack0;
   assign ack1       = r_ack1;
   assign rsp_valid0 = r_rsp_valid0;
   assign rsp_valid1 = r_rsp_valid1;
   assign rsp_data   = r_rsp_data;
   assign rsp_ovf    = r_rsp_ovf;
   assign rsp_err    = r_rsp_err;
   assign busy       = (r_state != S_IDLE);
   assign add_start  = r_start;
   assign add_in1    = r_in1;
   assign add_in2    = r_in2;
   assign add_sub    = r_sub;

endmodule
